// File: rtl/vector_writeback_unit_pkg.sv
// Shared vector-pipeline definitions: register/result widths and the
// writeback entry record reused by the RR-stage bypass muxing.
package vector_writeback_unit_pkg;

    localparam int VEC_ADDR_W = 5;
    localparam int VEC_DATA_W = 64;
    localparam int WB_DEPTH   = 4;

    typedef struct packed {
        logic [VEC_ADDR_W-1:0] addr;
        logic [VEC_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int wb_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vector_writeback_unit_fifo.sv
// In-order writeback FIFO: storage, wrap-bit pointers, per-entry valid bits
// and occupancy. Callers only push when !full and pop when !empty.
module vector_writeback_unit_fifo
    import vector_writeback_unit_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = VEC_ADDR_W,
    parameter int DATA_W = VEC_DATA_W,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = wb_ptr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    output logic [IDX_W-1:0]  head_idx,
    output logic [DEPTH-1:0]  entry_valid,
    output logic [ADDR_W-1:0] entry_addr [DEPTH],
    output logic [DATA_W-1:0] entry_data [DEPTH],
    output logic              full,
    output logic              empty,
    output logic [PTR_W-1:0]  occupancy
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_idx;

    // The wrap bit makes pointer difference an exact count, so full and
    // empty need no separate tracking.
    assign wr_idx    = wr_ptr[IDX_W-1:0];
    assign head_idx  = rd_ptr[IDX_W-1:0];
    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == PTR_W'(DEPTH));
    assign empty     = (occupancy == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                entry_valid[head_idx] <= 1'b0;
                rd_ptr                <= rd_ptr + 1'b1;
            end
            if (push) begin
                entry_valid[wr_idx] <= 1'b1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            entry_addr[wr_idx] <= push_addr;
            entry_data[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/vector_writeback_unit.sv
// Vector commit/writeback stage: buffers EX results in order, drains them to
// the register file write port and offers a youngest-first bypass to RR.
module vector_writeback_unit
    import vector_writeback_unit_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = VEC_DATA_W,
    parameter int ADDR_W = VEC_ADDR_W,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_vd_addr,
    input  logic [DATA_W-1:0] ex_vd_data,
    output logic              rf_we,
    input  logic              rf_wready,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] byp_vs2_addr,
    input  logic [ADDR_W-1:0] byp_vs1_addr,
    output logic              byp_vs2_hit,
    output logic [DATA_W-1:0] byp_vs2_data,
    output logic              byp_vs1_hit,
    output logic [DATA_W-1:0] byp_vs1_data,
    output logic [PTR_W-1:0]  occupancy
);

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [IDX_W-1:0]  head_idx;
    logic [DEPTH-1:0]  entry_valid;
    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];
    logic [IDX_W-1:0]  scan_idx;

    // ex_ready depends only on registered state; a pop never frees a slot
    // for a push in the same cycle.
    assign ex_ready = !full;
    assign push     = ex_valid && ex_ready;
    assign rf_we    = !empty;
    assign pop      = rf_we && rf_wready;
    assign rf_waddr = entry_addr[head_idx];
    assign rf_wdata = entry_data[head_idx];

    vector_writeback_unit_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (push),
        .pop         (pop),
        .push_addr   (ex_vd_addr),
        .push_data   (ex_vd_data),
        .head_idx    (head_idx),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr),
        .entry_data  (entry_data),
        .full        (full),
        .empty       (empty),
        .occupancy   (occupancy)
    );

    // Scan oldest to youngest so later matches overwrite earlier ones; the
    // accepted push is applied last as the youngest candidate of all.
    always_comb begin
        byp_vs2_hit  = 1'b0;
        byp_vs2_data = '0;
        byp_vs1_hit  = 1'b0;
        byp_vs1_data = '0;
        scan_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_idx + IDX_W'(k);
            if (entry_valid[scan_idx] && (entry_addr[scan_idx] == byp_vs2_addr)) begin
                byp_vs2_hit  = 1'b1;
                byp_vs2_data = entry_data[scan_idx];
            end
            if (entry_valid[scan_idx] && (entry_addr[scan_idx] == byp_vs1_addr)) begin
                byp_vs1_hit  = 1'b1;
                byp_vs1_data = entry_data[scan_idx];
            end
        end
        if (push && (ex_vd_addr == byp_vs2_addr)) begin
            byp_vs2_hit  = 1'b1;
            byp_vs2_data = ex_vd_data;
        end
        if (push && (ex_vd_addr == byp_vs1_addr)) begin
            byp_vs1_hit  = 1'b1;
            byp_vs1_data = ex_vd_data;
        end
    end

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Scoreboard bench: directed and random traffic against a queue-based model
// of the pending writes, checked every cycle by an independent monitor.
module tb_vector_writeback_unit;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } exp_t;

    logic              clock;
    logic              reset_n;
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_vd_addr;
    logic [DATA_W-1:0] ex_vd_data;
    logic              rf_we;
    logic              rf_wready;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] byp_vs2_addr;
    logic [ADDR_W-1:0] byp_vs1_addr;
    logic              byp_vs2_hit;
    logic [DATA_W-1:0] byp_vs2_data;
    logic              byp_vs1_hit;
    logic [DATA_W-1:0] byp_vs1_data;
    logic [2:0]        occupancy;

    int   checks   = 0;
    int   failures = 0;
    exp_t pending[$];

    vector_writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_vd_addr   (ex_vd_addr),
        .ex_vd_data   (ex_vd_data),
        .rf_we        (rf_we),
        .rf_wready    (rf_wready),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .byp_vs2_addr (byp_vs2_addr),
        .byp_vs1_addr (byp_vs1_addr),
        .byp_vs2_hit  (byp_vs2_hit),
        .byp_vs2_data (byp_vs2_data),
        .byp_vs1_hit  (byp_vs1_hit),
        .byp_vs1_data (byp_vs1_data),
        .occupancy    (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference bypass: accepted push is youngest, then the pending queue
    // searched from its back (youngest) to its front (oldest).
    function automatic void bypass_model(input logic [ADDR_W-1:0] a, input bit accepted,
                                         output bit hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (accepted && ex_vd_addr == a) begin
            hit = 1'b1;
            d   = ex_vd_data;
            return;
        end
        for (int i = pending.size() - 1; i >= 0; i--) begin
            if (pending[i].a == a) begin
                hit = 1'b1;
                d   = pending[i].d;
                return;
            end
        end
    endfunction

    always @(negedge clock) begin
        bit              exp_ready;
        bit              accepted;
        bit              hit;
        logic [DATA_W-1:0] d;
        if (!reset_n) begin
            pending.delete();
            checkOutput("rst_rf_we", {63'd0, rf_we}, 64'd0);
            checkOutput("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
            checkOutput("rst_occupancy", {61'd0, occupancy}, 64'd0);
            checkOutput("rst_vs2_hit", {63'd0, byp_vs2_hit}, 64'd0);
        end else begin
            exp_ready = pending.size() < DEPTH;
            accepted  = ex_valid && exp_ready;
            checkOutput("ex_ready", {63'd0, ex_ready}, {63'd0, exp_ready});
            checkOutput("occupancy", {61'd0, occupancy}, 64'(pending.size()));
            checkOutput("rf_we", {63'd0, rf_we}, {63'd0, pending.size() != 0});
            if (pending.size() != 0) begin
                checkOutput("rf_waddr", {59'd0, rf_waddr}, {59'd0, pending[0].a});
                checkOutput("rf_wdata", rf_wdata, pending[0].d);
            end
            bypass_model(byp_vs2_addr, accepted, hit, d);
            checkOutput("vs2_hit", {63'd0, byp_vs2_hit}, {63'd0, hit});
            checkOutput("vs2_data", byp_vs2_data, d);
            bypass_model(byp_vs1_addr, accepted, hit, d);
            checkOutput("vs1_hit", {63'd0, byp_vs1_hit}, {63'd0, hit});
            checkOutput("vs1_data", byp_vs1_data, d);
            if (pending.size() != 0 && rf_wready)
                void'(pending.pop_front());
            if (accepted)
                pending.push_back('{a: ex_vd_addr, d: ex_vd_data});
        end
    end

    task automatic applyStimulus(input bit v, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input bit wr);
        @(posedge clock);
        #1;
        ex_valid   = v;
        ex_vd_addr = a;
        ex_vd_data = d;
        rf_wready  = wr;
    endtask

    initial begin
        reset_n      = 1'b0;
        ex_valid     = 1'b0;
        ex_vd_addr   = '0;
        ex_vd_data   = '0;
        rf_wready    = 1'b0;
        byp_vs2_addr = 5'd3;
        byp_vs1_addr = 5'd9;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Single push, drained on the following cycle
        applyStimulus(1, 5'd3, 64'hDEAD_BEEF_0000_0001, 1);
        applyStimulus(0, 5'd0, 64'd0, 1);
        applyStimulus(0, 5'd0, 64'd0, 1);

        // Fill to full, a fifth request is held off, then drain in order
        byp_vs2_addr = 5'd4;
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 5'(i), 64'(i) * 64'h0101, 0);
        applyStimulus(1, 5'd5, 64'h5555, 0);
        applyStimulus(1, 5'd5, 64'h5555, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 5'd0, 64'd0, 1);

        // Full FIFO with a waiting push: pop first, then steady push+pop
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 5'(10 + i), 64'(100 + i), 0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1, 5'(20 + i), 64'(200 + i), 1);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 5'd0, 64'd0, 1);

        // Bypass priority on repeated destination 7
        byp_vs2_addr = 5'd7;
        byp_vs1_addr = 5'd9;
        applyStimulus(1, 5'd7, 64'h11, 0);
        applyStimulus(1, 5'd7, 64'h22, 0);
        applyStimulus(0, 5'd7, 64'h33, 0);
        applyStimulus(1, 5'd7, 64'h33, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 5'd0, 64'd0, 1);

        // Stall with a held head entry
        byp_vs1_addr = 5'd5;
        applyStimulus(1, 5'd5, 64'hAA, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 5'd0, 64'd0, 0);
        applyStimulus(0, 5'd0, 64'd0, 1);
        applyStimulus(0, 5'd0, 64'd0, 1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            byp_vs2_addr = 5'($urandom_range(0, 7));
            byp_vs1_addr = 5'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                          {$urandom, $urandom}, $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 5'd0, 64'd0, 1);

        // Asynchronous reset in the middle of a drain
        byp_vs2_addr = 5'd12;
        byp_vs1_addr = 5'd13;
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 5'(11 + i), 64'(300 + i), 0);
        applyStimulus(0, 5'd0, 64'd0, 1);
        @(posedge clock);
        #3;
        ex_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        checkOutput("async_rf_we", {63'd0, rf_we}, 64'd0);
        checkOutput("async_occupancy", {61'd0, occupancy}, 64'd0);
        checkOutput("async_vs2_hit", {63'd0, byp_vs2_hit}, 64'd0);
        checkOutput("async_vs1_hit", {63'd0, byp_vs1_hit}, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 5'd0, 64'd0, 1);

        // Short random burst after reset
        for (int i = 0; i < 100; i++) begin
            byp_vs2_addr = 5'($urandom_range(0, 7));
            byp_vs1_addr = 5'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                          {$urandom, $urandom}, $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 5'd0, 64'd0, 1);
        @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
